display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexing scheduler for the shared 4-digit common-anode 7-segment display.
- Takes the four BCD digits from the minute/hour split datapath (dig0..dig3), the display enable and the blink request from the control FSM.
- Grants the segment bus to one digit per refresh slot, with dead-time, frame-coherent snapshotting, blink blanking and digit decode.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (>= DEAD_CYC+2)
- DEAD_CYC, 4, cycles at slot start with all anodes off (ghosting guard), >= 1
- BLINK_SLOTS, 400, digit slots per blink half-period

Ports:
- clk  input  1  system clock
- reset_  input  1  asynchronous active-low reset
- dig0  input  4  BCD minutes units
- dig1  input  4  BCD minutes tens
- dig2  input  4  BCD hours units
- dig3  input  4  BCD hours tens
- en_afisaj  input  1  display enable; 0 blanks all digits
- palpaie  input  1  blink request from control FSM
- blink_sel  input  2  blink field: 00 none, 01 minutes (dig0,dig1), 10 hours (dig2,dig3), 11 all
- an  output  4  anode selects, active-low, an[i] drives digit i
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; used as hour/minute colon
- frame_start  output  1  one-cycle pulse when slot 0 begins

Behaviour:
- Reset (async, reset_=0): an=4'b1111, seg=7'h7F, dp=1, frame_start=0, slot counter=0, digit index=0, blink counter=0, blink phase=ON, snapshot regs=0.
- Slot counter: counts 0..REFRESH_DIV-1, then wraps to 0. Wrap is the slot tick.
- Digit index: 2 bits, advances 0->1->2->3->0 on each slot tick.
- Snapshot: on the tick where the index wraps 3->0, all four dig inputs are captured together. Digits never tear within a frame. The first frame after reset displays zeros.
- frame_start: asserts in the cycle the slot counter is 0 and the index is 0.
- Slot states per digit, a 2-state FSM:
  - DEAD: slot counter < DEAD_CYC. an=1111, seg=7F, dp=1.
  - DRIVE: remainder of the slot. an has bit[index]=0, others 1. seg = decode(snapshot[index]).
- All outputs are registered. Outputs reflect the counter state of the previous cycle (latency 1).
- Decode: 0-9 use the standard patterns. Codes 10-15 display '-' (only g lit, seg=7'b0111111).
- Blink counter: counts slot ticks 0..BLINK_SLOTS-1. On wrap, the phase toggles.
- Blanking: a digit is blanked (an stays 1111 during DRIVE) when any of these holds:
  - en_afisaj=0;
  - palpaie=1, phase=OFF and blink_sel covers that digit.
- palpaie=0: the phase is ignored. The blink counter keeps running; it is not reset.
- en_afisaj, palpaie and blink_sel are sampled every cycle. A change mid-slot takes effect on the next cycle, with no wait for the slot boundary.
- dp: 0 only in DRIVE of digit 2 while phase=ON and en_afisaj=1 (blinking colon at the blink rate). Otherwise 1.
- Reset mid-slot: all counters and outputs return to their reset values immediately.
- No outputs combinationally depend on inputs.

Optional Feature:
- Macro: DISPLAY_LZ_BLANK_EN.
- Defined: digit 3 is blanked (an[3] stays 1 for the whole slot) when its snapshot equals 0, giving " 9:05" instead of "09:05". This applies regardless of the blink state.
- Undefined: digit 3 displays '0' normally.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package: segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF; blink_sel encodings BLK_NONE/BLK_MIN/BLK_HOUR/BLK_ALL; slot FSM state encodings S_DEAD/S_DRIVE.
- One natural sub-module, bcd_to_seg: a pure combinational 4-bit to 7-bit decoder, reused by any later segment driver.
- Counters, snapshot and FSM stay in the top block.

Test Plan:
1. REFRESH_DIV=8, DEAD_CYC=2, BLINK_SLOTS=4; release reset with dig={3,2,5,9}.
   - First frame shows 0s.
   - Frame 2 digit 0 slot: 2 cycles of an=1111, then 6 cycles of an=1110 with seg=7'b0010000 ('9').
   - Then digit 1 with an=1101.
2. Change dig0 from 9 to 4 in mid-frame (during the digit 2 slot).
   - Rest of the frame still shows 9.
   - Next frame's digit 0 shows 7'b0011001 ('4').
   - frame_start pulses exactly once per 32 cycles.
3. palpaie=1, blink_sel=01.
   - Digits 0/1 alternately lit for 4 slots and dark for 4 slots; digits 2/3 lit continuously.
   - Repeat with blink_sel=10: the blanking moves to digits 2/3.
4. dig2=4'hC.
   - seg=7'b0111111 during the digit 2 DRIVE.
   - dp=0 in that slot only while phase=ON.
5. en_afisaj dropped mid-DRIVE: an=1111 from the next cycle.
   - Assert reset_=0 asynchronously mid-slot: outputs reach the reset values without a clock edge.
6. dig3=0, with and without DISPLAY_LZ_BLANK_EN.
   - Defined: an[3] never goes low.
   - Undefined: an[3]=0 with seg=7'b1000000.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the 7-segment display path: active-low segment patterns,
// blink field encodings and the per-digit slot state encoding.
package display_scan_ctrl_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [1:0] BLK_NONE = 2'b00;
  localparam logic [1:0] BLK_MIN  = 2'b01;
  localparam logic [1:0] BLK_HOUR = 2'b10;
  localparam logic [1:0] BLK_ALL  = 2'b11;

  typedef enum logic {
    S_DEAD  = 1'b0,
    S_DRIVE = 1'b1
  } slot_state_e;

  // Minutes are digits 0/1, hours are digits 2/3.
  function automatic logic blink_covers(input logic [1:0] sel, input logic [1:0] idx);
    logic hit;
    hit = 1'b0;
    case (sel)
      BLK_MIN:  hit = ~idx[1];
      BLK_HOUR: hit = idx[1];
      BLK_ALL:  hit = 1'b1;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_bcd_to_seg.sv
// Pure combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display with dead-time,
// frame snapshot, blink blanking and colon. Optional DISPLAY_LZ_BLANK_EN blanks a leading zero on digit 3.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 4,
  parameter int BLINK_SLOTS = 400
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic       en_afisaj,
  input  logic       palpaie,
  input  logic [1:0] blink_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LIMIT = CNT_W'(DEAD_CYC);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_SLOTS - 1);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_on_q, phase_on_d;
  logic [3:0][3:0]  snap_q, snap_d;
  slot_state_e      state_q, state_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_start_q, frame_start_d;

  logic             slot_tick;
  logic             lz_blank;
  logic             blank;
  logic [6:0]       dec_seg;

  bcd_to_seg u_dec (
    .bcd (snap_q[idx_q]),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      slot_cnt_q    <= '0;
      idx_q         <= 2'd0;
      blink_cnt_q   <= '0;
      phase_on_q    <= 1'b1;
      snap_q        <= '0;
      state_q       <= S_DEAD;
      an_q          <= 4'b1111;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_on_q    <= phase_on_d;
      snap_q        <= snap_d;
      state_q       <= state_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Digits are captured only at the frame boundary so a frame never mixes old and new values.
  always_comb begin
    slot_tick   = (slot_cnt_q == SLOT_LAST);
    slot_cnt_d  = slot_cnt_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_on_d  = phase_on_q;
    snap_d      = snap_q;
    if (slot_tick) begin
      slot_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
      if (idx_q == 2'd3) begin
        snap_d = {dig3, dig2, dig1, dig0};
      end
    end
    state_d = (slot_cnt_d < DEAD_LIMIT) ? S_DEAD : S_DRIVE;
  end

`ifdef DISPLAY_LZ_BLANK_EN
  assign lz_blank = (idx_q == 2'd3) && (snap_q[3] == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif

  // Output registers are computed from this cycle's counters and live control inputs.
  always_comb begin
    blank         = !en_afisaj || lz_blank ||
                    (palpaie && !phase_on_q && blink_covers(blink_sel, idx_q));
    an_d          = 4'b1111;
    seg_d         = SEG_OFF;
    dp_d          = 1'b1;
    frame_start_d = (slot_cnt_q == '0) && (idx_q == 2'd0);
    case (state_q)
      S_DRIVE: begin
        seg_d = dec_seg;
        if (!blank) begin
          an_d = ~(4'b0001 << idx_q);
        end
        if ((idx_q == 2'd2) && phase_on_q && en_afisaj) begin
          dp_d = 1'b0;
        end
      end
      default: begin
        an_d = 4'b1111;
      end
    endcase
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with a small refresh geometry
// (8-cycle slots, 2 dead cycles, 4-slot blink half-period); follows DISPLAY_LZ_BLANK_EN if defined.
module tb_display_scan_ctrl;

  localparam logic [6:0] P0    = 7'b1000000;
  localparam logic [6:0] P3    = 7'b0110000;
  localparam logic [6:0] P4    = 7'b0011001;
  localparam logic [6:0] P5    = 7'b0010010;
  localparam logic [6:0] P9    = 7'b0010000;
  localparam logic [6:0] PDASH = 7'b0111111;
  localparam logic [6:0] POFF  = 7'b1111111;

  logic       clk;
  logic       reset_;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       en_afisaj;
  logic       palpaie;
  logic [1:0] blink_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int checkCount;
  int errorCount;
  int edgeCount;
  int frameStarts;

  display_scan_ctrl #(
    .REFRESH_DIV (8),
    .DEAD_CYC    (2),
    .BLINK_SLOTS (4)
  ) dut (
    .clk         (clk),
    .reset_      (reset_),
    .dig0        (dig0),
    .dig1        (dig1),
    .dig2        (dig2),
    .dig3        (dig3),
    .en_afisaj   (en_afisaj),
    .palpaie     (palpaie),
    .blink_sel   (blink_sel),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side count of clock edges since reset release; state index s is visible after edge s+1.
  always @(posedge clk or negedge reset_) begin
    if (!reset_) edgeCount <= 0;
    else         edgeCount <= edgeCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkDisplay(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg,
                              input logic expDp);
    checkOutput($sformatf("%s.an", tag), 32'(an), 32'(expAn));
    checkOutput($sformatf("%s.seg", tag), 32'(seg), 32'(expSeg));
    checkOutput($sformatf("%s.dp", tag), 32'(dp), 32'(expDp));
  endtask

  task automatic applyStimulus(input logic en, input logic pal, input logic [1:0] sel);
    en_afisaj = en;
    palpaie   = pal;
    blink_sel = sel;
  endtask

  task automatic advanceTo(input int s);
    while (edgeCount < s + 1) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    frameStarts = 0;
    reset_      = 1'b0;
    {dig3, dig2, dig1, dig0} = {4'd3, 4'd2, 4'd5, 4'd9};
    applyStimulus(1'b1, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    checkDisplay("reset", 4'b1111, POFF, 1'b1);
    checkOutput("reset.frame_start", 32'(frame_start), 32'd0);
    reset_ = 1'b1;

    // Frame 0: snapshot still zero
    advanceTo(0);
    checkDisplay("f0.d0.dead", 4'b1111, POFF, 1'b1);
    checkOutput("f0.frame_start", 32'(frame_start), 32'd1);
    advanceTo(1);
    checkOutput("f0.frame_start_off", 32'(frame_start), 32'd0);
    advanceTo(2);
    checkDisplay("f0.d0.drive", 4'b1110, P0, 1'b1);
    advanceTo(18);
    checkDisplay("f0.d2.colon", 4'b1011, P0, 1'b0);
    advanceTo(26);
`ifdef DISPLAY_LZ_BLANK_EN
    checkOutput("f0.d3.lz.an", 32'(an), 32'hF);
`else
    checkDisplay("f0.d3.zero", 4'b0111, P0, 1'b1);
`endif

    // Frame 1: captured {3,2,5,9}, blink phase OFF
    advanceTo(32);
    checkDisplay("f1.d0.dead0", 4'b1111, POFF, 1'b1);
    checkOutput("f1.frame_start", 32'(frame_start), 32'd1);
    advanceTo(33);
    checkDisplay("f1.d0.dead1", 4'b1111, POFF, 1'b1);
    advanceTo(34);
    checkDisplay("f1.d0.nine", 4'b1110, P9, 1'b1);
    advanceTo(39);
    checkDisplay("f1.d0.last", 4'b1110, P9, 1'b1);
    advanceTo(40);
    checkDisplay("f1.d1.dead", 4'b1111, POFF, 1'b1);
    advanceTo(42);
    checkDisplay("f1.d1.five", 4'b1101, P5, 1'b1);
    advanceTo(50);
    checkDisplay("f1.d2.colon_off", 4'b1011, 7'b0100100, 1'b1);
    dig0 = 4'd4;
    advanceTo(58);
    checkDisplay("f1.d3.three", 4'b0111, P3, 1'b1);

    // Frames 2-3: new dig0 appears, count frame_start pulses, plant an invalid code
    for (int s = 64; s < 128; s++) begin
      advanceTo(s);
      if (frame_start === 1'b1) frameStarts++;
      if (s == 66) checkDisplay("f2.d0.four", 4'b1110, P4, 1'b1);
      if (s == 70) dig2 = 4'hC;
      if (s == 114) checkDisplay("f3.d2.dash_off", 4'b1011, PDASH, 1'b1);
    end
    checkOutput("frame_start.count", 32'(frameStarts), 32'd2);
    advanceTo(146);
    checkDisplay("f4.d2.dash_on", 4'b1011, PDASH, 1'b0);

    // Blink minutes: frame 5 phase OFF, frame 6 phase ON
    advanceTo(159);
    applyStimulus(1'b1, 1'b1, 2'b01);
    advanceTo(162);
    checkOutput("blkmin.f5.d0", 32'(an), 32'hF);
    advanceTo(170);
    checkOutput("blkmin.f5.d1", 32'(an), 32'hF);
    advanceTo(178);
    checkOutput("blkmin.f5.d2", 32'(an), 32'hB);
    advanceTo(186);
    checkOutput("blkmin.f5.d3", 32'(an), 32'h7);
    advanceTo(194);
    checkOutput("blkmin.f6.d0", 32'(an), 32'hE);
    advanceTo(202);
    checkOutput("blkmin.f6.d1", 32'(an), 32'hD);

    // Blink hours: frame 7 phase OFF
    advanceTo(223);
    applyStimulus(1'b1, 1'b1, 2'b10);
    advanceTo(226);
    checkOutput("blkhr.f7.d0", 32'(an), 32'hE);
    advanceTo(234);
    checkOutput("blkhr.f7.d1", 32'(an), 32'hD);
    advanceTo(242);
    checkOutput("blkhr.f7.d2", 32'(an), 32'hF);
    checkOutput("blkhr.f7.dp", 32'(dp), 32'd1);
    advanceTo(250);
    checkOutput("blkhr.f7.d3", 32'(an), 32'hF);

    // Enable drop mid-DRIVE in frame 8
    advanceTo(255);
    applyStimulus(1'b1, 1'b0, 2'b00);
    advanceTo(260);
    checkDisplay("f8.d0.on", 4'b1110, P4, 1'b1);
    en_afisaj = 1'b0;
    advanceTo(261);
    checkOutput("en_drop.an", 32'(an), 32'hF);
    en_afisaj = 1'b1;
    advanceTo(262);
    checkOutput("en_back.an", 32'(an), 32'hE);
    advanceTo(266);
    checkDisplay("f8.d1.five", 4'b1101, P5, 1'b1);

    // Asynchronous reset between clock edges
    #2 reset_ = 1'b0;
    #1;
    checkDisplay("async_reset", 4'b1111, POFF, 1'b1);
    checkOutput("async_reset.frame_start", 32'(frame_start), 32'd0);
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    advanceTo(0);
    checkOutput("rst2.frame_start", 32'(frame_start), 32'd1);
    advanceTo(2);
    checkDisplay("rst2.d0.zero", 4'b1110, P0, 1'b1);
    advanceTo(26);
`ifdef DISPLAY_LZ_BLANK_EN
    checkOutput("rst2.d3.lz.an", 32'(an), 32'hF);
`else
    checkDisplay("rst2.d3.zero", 4'b0111, P0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
